ysyx_24080006_hzu: RTL

YSYX_24080006_HZU -- requirements
Module: ysyx_24080006_hzu

---
 rtl/ysyx_24080006_hzu.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ysyx_24080006_hzu.sv
// rtl/ysyx_24080006_hzu.sv - issue hazard unit: per-register pending scoreboard, inflight limit, redirect/flush FSM (optional bypass: YSYX_24080006_FWD_EN)
module ysyx_24080006_hzu #(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_rs1_en,
    input  logic        id_rs2_en,
    input  logic        id_rd_en,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        wb_rd_en,
    input  logic        redirect_req,
    input  logic [31:0] redirect_pc,
    output logic        flush,
    output logic        ifu_redirect,
    output logic [31:0] ifu_pc,
    input  logic        ifu_ready,
    output logic [2:0]  inflight
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    localparam logic [2:0] MAX_Q = 3'(MAX_INFLIGHT);

    state_t      state_q, state_d;
    logic [2:0]  pend_q [32];
    logic [2:0]  pend_d [32];
    logic [2:0]  inflight_q, inflight_d;
    logic [31:0] ifu_pc_q, ifu_pc_d;

    logic run;
    logic retire;
    logic issue;
    logic pend_inc;
    logic pend_dec;
    logic haz_rs1;
    logic haz_rs2;
    logic hazard;

    assign run = (state_q == ST_RUN);

    // A retirement only counts in RUN and when something is actually in flight.
    assign retire   = run & wb_valid & (inflight_q != 3'd0);
    assign pend_dec = retire & wb_rd_en & (wb_rd != 5'd0) & (pend_q[wb_rd] != 3'd0);

    // Source hazard check; with the bypass, a last pending write retiring this cycle is not a hazard.
    always_comb begin
        haz_rs1 = id_rs1_en & (id_rs1 != 5'd0) & (pend_q[id_rs1] != 3'd0);
        haz_rs2 = id_rs2_en & (id_rs2 != 5'd0) & (pend_q[id_rs2] != 3'd0);
`ifdef YSYX_24080006_FWD_EN
        if (pend_dec && (wb_rd == id_rs1) && (pend_q[id_rs1] == 3'd1)) begin
            haz_rs1 = 1'b0;
        end
        if (pend_dec && (wb_rd == id_rs2) && (pend_q[id_rs2] == 3'd1)) begin
            haz_rs2 = 1'b0;
        end
`endif
    end

    assign hazard   = haz_rs1 | haz_rs2;
    assign id_ready = run & ~hazard & (inflight_q < MAX_Q);
    assign issue    = id_valid & id_ready;
    assign pend_inc = issue & id_rd_en & (id_rd != 5'd0);

    // Next-state for the pending scoreboard: +1 on issue, -1 on retire, cleared by FLUSH.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            pend_d[i] = pend_q[i];
        end
        if (state_q == ST_FLUSH) begin
            for (int i = 0; i < 32; i++) begin
                pend_d[i] = 3'd0;
            end
        end else if (run) begin
            for (int i = 1; i < 32; i++) begin
                if (pend_inc && (id_rd == 5'(i)) && !(pend_dec && (wb_rd == 5'(i)))) begin
                    pend_d[i] = pend_q[i] + 3'd1;
                end else if (pend_dec && (wb_rd == 5'(i)) && !(pend_inc && (id_rd == 5'(i)))) begin
                    pend_d[i] = pend_q[i] - 3'd1;
                end
            end
        end
    end

    // Redirect FSM next-state, inflight count, latched redirect PC and FSM outputs.
    always_comb begin
        state_d      = state_q;
        inflight_d   = inflight_q;
        ifu_pc_d     = ifu_pc_q;
        flush        = 1'b0;
        ifu_redirect = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (issue && !retire) begin
                    inflight_d = inflight_q + 3'd1;
                end else if (retire && !issue) begin
                    inflight_d = inflight_q - 3'd1;
                end
                if (redirect_req) begin
                    ifu_pc_d = redirect_pc;
                    state_d  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush      = 1'b1;
                inflight_d = 3'd0;
                state_d    = ST_REDIR;
            end
            ST_REDIR: begin
                ifu_redirect = 1'b1;
                if (ifu_ready) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State registers; reset overrides everything, including an in-progress redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            inflight_q <= 3'd0;
            ifu_pc_q   <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                pend_q[i] <= 3'd0;
            end
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            ifu_pc_q   <= ifu_pc_d;
            for (int i = 0; i < 32; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

    assign inflight = inflight_q;
    assign ifu_pc   = ifu_pc_q;

endmodule
